// File: rtl/inst_sram_like_to_axi_if.sv
// Signal bundle between the instruction sram-like port and the AXI read channels.
// master = bridge view (drives AR/R handshake and sram-like replies), slave = CPU/AXI-side view.
interface inst_sram_like_to_axi_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  inst_req, inst_wr, inst_size, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output inst_req, inst_wr, inst_size, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/inst_sram_like_to_axi.sv
// Single-outstanding sram-like -> AXI4 single-beat read bridge; addr_ok->data_ok min 2 cycles (3 with INST_RDATA_BUF_EN).
// Stalls on arready/rvalid add one cycle each; new requests are refused until the current read returns.
module inst_sram_like_to_axi #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    inst_sram_like_to_axi_if.master bus
);

`ifdef INST_RDATA_BUF_EN
    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, AR, R} state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        w_accept;
    logic        w_hit;
    logic        w_arvalid;
    logic        w_rready;
    logic        w_data_ok;
    logic        w_unused;

    // Beats carrying a foreign id are accepted (rready) but never returned to the CPU.
    always_comb begin
        w_accept  = (r_state == IDLE) & bus.inst_req & ~bus.inst_wr & ~rst;
        w_hit     = (r_state == R) & bus.rvalid & (bus.rid == AXI_ID) & ~rst;
        w_next    = r_state;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_data_ok = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_next = AR;
            end
            AR: begin
                w_arvalid = ~rst;
                if (bus.arready) w_next = R;
            end
            R: begin
                w_rready = ~rst;
`ifdef INST_RDATA_BUF_EN
                if (w_hit) w_next = DONE;
`else
                w_data_ok = w_hit;
                if (w_hit) w_next = IDLE;
`endif
            end
`ifdef INST_RDATA_BUF_EN
            DONE: begin
                w_data_ok = ~rst;
                w_next    = IDLE;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= 32'd0;
            r_size  <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= bus.inst_addr;
                r_size <= bus.inst_size;
            end
        end
    end

`ifdef INST_RDATA_BUF_EN
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
        end else if (w_hit) begin
            r_rdata <= bus.rdata;
        end
    end

    assign bus.inst_rdata = r_rdata;
`else
    assign bus.inst_rdata = bus.rdata;
`endif

    assign bus.inst_addr_ok = w_accept;
    assign bus.inst_data_ok = w_data_ok;
    assign bus.arid         = AXI_ID;
    assign bus.araddr       = r_addr;
    assign bus.arlen        = 8'd0;
    assign bus.arsize       = {1'b0, r_size};
    assign bus.arburst      = 2'b01;
    assign bus.arvalid      = w_arvalid;
    assign bus.rready       = w_rready;

    // Single-beat reads make rlast redundant and errors are not reported upstream.
    assign w_unused = ^{bus.rresp, bus.rlast};

endmodule

// File: tb/tb_inst_sram_like_to_axi.sv
// Directed + randomized checks of the sram-like to AXI read bridge against a queue-based reference.
module tb_inst_sram_like_to_axi;
    logic clk = 1'b0;
    logic rst;

    inst_sram_like_to_axi_if bus();

    inst_sram_like_to_axi #(.AXI_ID(4'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          n_req = 0;
    int          n_ar_expected = 0;
    int          mon_ar_hs = 0;
    int          mon_data_ok = 0;
    int          mon_overlap = 0;
    logic [31:0] exp_q[$];

    // Protocol-level counters sampled just before each rising edge.
    always @(posedge clk) begin
        if (bus.arvalid === 1'b1 && bus.arready === 1'b1) mon_ar_hs++;
        if (bus.inst_data_ok === 1'b1) mon_data_ok++;
        if (bus.inst_addr_ok === 1'b1 && bus.inst_data_ok === 1'b1) mon_overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        bus.inst_req  = 1'b0;
        bus.inst_wr   = 1'b0;
        bus.inst_size = 2'd0;
        bus.inst_addr = 32'd0;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        bus.rid       = 4'd0;
        bus.rdata     = 32'd0;
        bus.rresp     = 2'd0;
        bus.rlast     = 1'b0;
    endtask

    // One read: ar_st arready stalls, r_st empty R cycles, bad foreign-id beats before the real one.
    task automatic do_read(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                           input int ar_st, input int r_st, input int bad, input bit hold_req);
        bus.inst_req  = 1'b1;
        bus.inst_wr   = 1'b0;
        bus.inst_addr = addr;
        bus.inst_size = size;
        #1;
        chk("req_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd1);
        chk("req_data_ok", {31'd0, bus.inst_data_ok}, 32'd0);
        exp_q.push_back(data);
        n_req++;
        n_ar_expected++;
        step();
        if (hold_req) bus.inst_addr = $urandom;
        else          bus.inst_req  = 1'b0;
        bus.inst_size = 2'($urandom);
        for (int i = 0; i < ar_st; i++) begin
            bus.arready = 1'b0;
            #1;
            chk("ar_stall_arvalid", {31'd0, bus.arvalid}, 32'd1);
            chk("ar_stall_araddr", bus.araddr, addr);
            chk("ar_stall_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd0);
            step();
        end
        bus.arready = 1'b1;
        #1;
        chk("ar_arvalid", {31'd0, bus.arvalid}, 32'd1);
        chk("ar_araddr", bus.araddr, addr);
        chk("ar_arsize", {29'd0, bus.arsize}, {30'd0, size});
        chk("ar_arlen", {24'd0, bus.arlen}, 32'd0);
        chk("ar_arburst", {30'd0, bus.arburst}, 32'd1);
        chk("ar_arid", {28'd0, bus.arid}, 32'd0);
        chk("ar_rready", {31'd0, bus.rready}, 32'd0);
        step();
        bus.arready = 1'b0;
        for (int i = 0; i < r_st; i++) begin
            bus.rvalid = 1'b0;
            bus.rdata  = $urandom;
            #1;
            chk("r_stall_rready", {31'd0, bus.rready}, 32'd1);
            chk("r_stall_data_ok", {31'd0, bus.inst_data_ok}, 32'd0);
            chk("r_stall_arvalid", {31'd0, bus.arvalid}, 32'd0);
            step();
        end
        for (int i = 0; i < bad; i++) begin
            bus.rvalid = 1'b1;
            bus.rid    = 4'($urandom_range(1, 15));
            bus.rdata  = $urandom;
            bus.rlast  = 1'($urandom);
            #1;
            chk("bad_id_rready", {31'd0, bus.rready}, 32'd1);
            chk("bad_id_data_ok", {31'd0, bus.inst_data_ok}, 32'd0);
            step();
        end
        bus.rvalid = 1'b1;
        bus.rid    = 4'd0;
        bus.rdata  = data;
        bus.rresp  = 2'($urandom);
        bus.rlast  = 1'b1;
        #1;
`ifdef INST_RDATA_BUF_EN
        chk("beat_rready", {31'd0, bus.rready}, 32'd1);
        chk("beat_data_ok_early", {31'd0, bus.inst_data_ok}, 32'd0);
        step();
        bus.rvalid = 1'b0;
        bus.rdata  = $urandom;
        #1;
`endif
        chk("done_data_ok", {31'd0, bus.inst_data_ok}, 32'd1);
        chk("done_rdata", bus.inst_rdata, exp_q.pop_front());
        chk("done_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd0);
        step();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
    endtask

    initial begin
        quiet_inputs();
        rst = 1'b1;
        @(negedge clk);
        bus.inst_req = 1'b1;
        #1;
        chk("rst_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd0);
        step();
        bus.inst_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_arvalid", {31'd0, bus.arvalid}, 32'd0);
        chk("rst_rready", {31'd0, bus.rready}, 32'd0);
        chk("rst_data_ok", {31'd0, bus.inst_data_ok}, 32'd0);
        chk("rst_araddr", bus.araddr, 32'd0);
        chk("rst_arsize", {29'd0, bus.arsize}, 32'd0);
        chk("rst_rdata", bus.inst_rdata, 32'd0);
        step();

        do_read(32'hBFC0_0000, 2'd2, 32'h3C1D_BFC0, 0, 0, 0, 1'b0);
        do_read(32'h8000_0040, 2'd2, 32'h1234_5678, 4, 0, 0, 1'b0);
        do_read(32'h0000_1000, 2'd2, 32'hA5A5_0001, 0, 0, 0, 1'b1);
        do_read(32'h0000_1004, 2'd2, 32'hA5A5_0002, 0, 0, 0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            bus.inst_req  = 1'b1;
            bus.inst_wr   = 1'b1;
            bus.inst_addr = 32'h0000_2000;
            #1;
            chk("wr_addr_ok", {31'd0, bus.inst_addr_ok}, 32'd0);
            chk("wr_arvalid", {31'd0, bus.arvalid}, 32'd0);
            step();
        end
        bus.inst_req = 1'b0;
        bus.inst_wr  = 1'b0;

        do_read(32'h0000_3000, 2'd2, 32'hDEAD_BEEF, 0, 1, 1, 1'b0);

        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0000_4000;
        bus.inst_size = 2'd2;
        n_ar_expected++;
        step();
        bus.inst_req = 1'b0;
        bus.arready  = 1'b1;
        step();
        bus.arready = 1'b0;
        #1;
        chk("midr_rready", {31'd0, bus.rready}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rvalid = 1'b1;
        bus.rid    = 4'd0;
        bus.rdata  = 32'h0BAD_0BAD;
        #1;
        chk("midr_arvalid", {31'd0, bus.arvalid}, 32'd0);
        chk("midr_rready_after", {31'd0, bus.rready}, 32'd0);
        chk("midr_data_ok", {31'd0, bus.inst_data_ok}, 32'd0);
        chk("midr_araddr", bus.araddr, 32'd0);
        step();
        bus.rvalid = 1'b0;
        do_read(32'h0000_5000, 2'd1, 32'hCAFE_F00D, 0, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            do_read($urandom, 2'($urandom), $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
        end
        bus.inst_req = 1'b0;
        step();
        step();

        chk("total_data_ok", mon_data_ok, n_req);
        chk("total_ar_handshakes", mon_ar_hs, n_ar_expected);
        chk("addr_ok_data_ok_overlap", mon_overlap, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
